// File: rtl/sng_pkg.sv
// Shared defaults and state encoding for the
// stochastic number generator.
package sng_pkg;

    localparam int unsigned WIDTH_DEF = 4;
    localparam logic [3:0]  SEED_DEF  = 4'b0001;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } sng_state_t;

endpackage

// File: rtl/sng_lfsr.sv
// De Bruijn sequencer: an LFSR with the all-zero
// state spliced in so every WIDTH-bit value appears.
module sng_lfsr
    import sng_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             en,
    input  logic [WIDTH-1:0] seed,
    output logic [WIDTH-1:0] state
);

    logic             fb;
    logic [WIDTH-1:0] r_q;

    // Flipping the feedback at the zero boundary inserts 0
    // between 100..0 and 00..01.
    always_comb begin
        fb = r_q[WIDTH-1] ^ r_q[WIDTH-2]
           ^ (r_q[WIDTH-2:0] == '0);
    end

    always_ff @(posedge clk) begin
        if (rst || load) begin
            r_q <= seed;
        end else if (en) begin
            r_q <= {r_q[WIDTH-2:0], fb};
        end
    end

    assign state = r_q;

endmodule

// File: rtl/sng.sv
// Binary-to-stochastic converter: each RUN cycle emits
// (x_q > r) against a full-period random source.
module sng
    import sng_pkg::*;
#(
    parameter int unsigned      WIDTH = WIDTH_DEF,
    parameter logic [WIDTH-1:0] SEED  = WIDTH'(SEED_DEF)
) (
    input  logic             i_clk_sng,
    input  logic             i_rst_sng,
    input  logic [WIDTH-1:0] i_x_bn,
    input  logic             i_start_sng,
    input  logic             i_stop_sng,
    output logic             o_sn_bit
);

    sng_state_t       state_q;
    sng_state_t       state_d;
    logic [WIDTH-1:0] x_q;
    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] r;
    logic             lfsr_load;
    logic             lfsr_en;
    logic             bit_d;

    sng_lfsr #(
        .WIDTH (WIDTH)
    ) u_lfsr (
        .clk   (i_clk_sng),
        .rst   (i_rst_sng),
        .load  (lfsr_load),
        .en    (lfsr_en),
        .seed  (SEED),
        .state (r)
    );

    always_comb begin
        state_d   = state_q;
        lfsr_load = 1'b0;
        lfsr_en   = 1'b0;
        bit_d     = 1'b0;
        if (i_start_sng) begin
            state_d   = RUN;
            lfsr_load = 1'b1;
        end else if (i_stop_sng) begin
            state_d = IDLE;
        end else if (state_q == RUN) begin
            lfsr_en = 1'b1;
            bit_d   = (x_q > r);
        end
    end

    always_ff @(posedge i_clk_sng) begin
        if (i_rst_sng) begin
            state_q  <= IDLE;
            x_q      <= '0;
            cnt_q    <= '0;
            o_sn_bit <= 1'b0;
        end else begin
            state_q  <= state_d;
            o_sn_bit <= bit_d;
            if (i_start_sng) begin
                x_q   <= i_x_bn;
                cnt_q <= '0;
            end else if (lfsr_en) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sng.sv
// Directed bench for sng: streams are checked bit by
// bit against a hand-derived de Bruijn table.
module tb_sng;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] x;
    logic       start;
    logic       stop;
    logic       sn;

    int n_vec = 0;
    int n_bad = 0;

    // r sequence from SEED=1, worked out by hand
    int rseq [16] = '{1, 2, 4, 9, 3, 6, 13, 10,
                      5, 11, 7, 15, 14, 12, 8, 0};

    sng u_dut (
        .i_clk_sng   (clk),
        .i_rst_sng   (rst),
        .i_x_bn      (x),
        .i_start_sng (start),
        .i_stop_sng  (stop),
        .o_sn_bit    (sn)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input int got,
                       input int exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got %0d exp %0d",
                     tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic go(input int xv, input logic stp);
        x     = 4'(xv);
        start = 1'b1;
        stop  = stp;
        tick();
        start = 1'b0;
        stop  = 1'b0;
        chk("start_edge", int'(sn), 0);
    endtask

    // Checks n bits from window position 0, optionally
    // jittering i_x_bn; returns the ones count.
    task automatic run_bits(input string tag,
                            input int xv,
                            input int n,
                            input bit jit,
                            output int ones);
        ones = 0;
        for (int k = 0; k < n; k++) begin
            if (jit) x = 4'($urandom_range(0, 15));
            tick();
            chk(tag, int'(sn),
                (xv > rseq[k % 16]) ? 1 : 0);
            ones += int'(sn);
        end
    endtask

    initial begin
        int ones;
        rst   = 1'b1;
        start = 1'b0;
        stop  = 1'b0;
        x     = 4'd0;

        // reset and idle
        tick();
        chk("rst0", int'(sn), 0);
        tick();
        chk("rst1", int'(sn), 0);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("idle", int'(sn), 0);
        end

        // popcount sweep
        for (int xv = 0; xv < 16; xv++) begin
            go(xv, 1'b0);
            run_bits("sweep", xv, 16, 1'b0, ones);
            chk($sformatf("pop%0d", xv), ones, xv);
        end

        // x=8, two windows back to back
        go(8, 1'b0);
        run_bits("x8_32", 8, 32, 1'b0, ones);
        chk("x8_pop32", ones, 16);

        // stop after 5 bits
        go(12, 1'b0);
        run_bits("x12", 12, 5, 1'b0, ones);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("stop", int'(sn), 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("stop_hold", int'(sn), 0);
        end

        // start wins over stop
        go(3, 1'b1);
        run_bits("x3", 3, 16, 1'b0, ones);
        chk("x3_pop", ones, 3);

        // reset mid-run, then fresh restart
        go(10, 1'b0);
        run_bits("x10a", 10, 7, 1'b0, ones);
        rst = 1'b1;
        tick();
        chk("rst_mid", int'(sn), 0);
        // reset overrides a concurrent start
        start = 1'b1;
        x     = 4'd15;
        tick();
        start = 1'b0;
        rst   = 1'b0;
        chk("rst_start", int'(sn), 0);
        tick();
        chk("rst_start_idle", int'(sn), 0);
        go(10, 1'b0);
        run_bits("x10b", 10, 16, 1'b0, ones);
        chk("x10_pop", ones, 10);

        // restart mid-window resets the window
        go(6, 1'b0);
        run_bits("x6a", 6, 9, 1'b0, ones);
        go(6, 1'b0);
        run_bits("x6b", 6, 16, 1'b0, ones);
        chk("x6_pop", ones, 6);

        // input jitter with start low
        go(5, 1'b0);
        run_bits("jit", 5, 32, 1'b1, ones);
        chk("jit_pop", ones, 10);

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/sng.md
SNG -- requirements
Module: sng

Interface
REQ-001 Parameter WIDTH, default 4, gives the binary input width and the random-source width.
REQ-002 Parameter SEED, default 4'b0001, is the random-source state loaded on reset and on start; it SHALL be nonzero-agnostic (any value legal).
REQ-003 i_clk_sng  input  1  is the single clock; all state SHALL update on its rising edge.
REQ-004 i_rst_sng  input  1  is the reset; it SHALL be synchronous and active-high.
REQ-005 i_x_bn  input  WIDTH  is the unsigned binary value to convert; it SHALL be sampled only when i_start_sng=1.
REQ-006 i_start_sng  input  1  is a start/restart strobe, active-high, sampled each rising edge.
REQ-007 i_stop_sng  input  1  is a stop request, active-high, sampled each rising edge.
REQ-008 o_sn_bit  output  1  is the registered stochastic bit stream.

Function
REQ-009 The FSM SHALL have two states: IDLE and RUN.
REQ-010 Start (i_start_sng=1) in any state SHALL do all of the following:
- latch i_x_bn into x_q;
- load the random source with SEED;
- clear the 2^WIDTH-cycle bit counter;
- enter RUN.
REQ-011 Start SHALL take priority over stop when both are 1 in the same cycle.
REQ-012 Stop without start SHALL enter IDLE and force o_sn_bit=0 from the next edge.
REQ-013 In IDLE, o_sn_bit SHALL be 0, and the random source and x_q SHALL hold.
REQ-014 In RUN, each edge SHALL register o_sn_bit = (x_q > r), unsigned, where r is the current random-source state, then advance r.
REQ-015 The first stream bit SHALL appear on o_sn_bit at the edge after the edge that sampled i_start_sng (one-cycle latency), and it is compared against r=SEED.
REQ-016 The random source SHALL be a WIDTH-bit de Bruijn sequencer. For WIDTH=4:
- next r = {r[2:0], fb};
- fb = r[3] ^ r[2] ^ (r[2:0]==3'b000).
REQ-017 The random source SHALL visit all 2^WIDTH states, including 0, exactly once per 2^WIDTH cycles (period 16 for WIDTH=4).
REQ-018 Consequence of REQ-016/017: any 2^WIDTH consecutive RUN bits SHALL contain exactly x_q ones.
- x=0 gives all zeros.
- x=15 gives 15 ones in 16 bits.
REQ-019 After 2^WIDTH bits, RUN SHALL continue and repeat the identical window until stop or start; the counter SHALL wrap to 0.
REQ-020 Changes on i_x_bn while i_start_sng=0 SHALL have no effect on the stream.
REQ-021 A start issued mid-window SHALL abandon the current window with no partial-state carry-over.

Reset
REQ-022 On reset, the block SHALL set:
- state to IDLE;
- o_sn_bit to 0;
- r to SEED;
- x_q to 0;
- the counter to 0.
REQ-023 Reset SHALL override start and stop in the same cycle.
REQ-024 Reset asserted mid-RUN SHALL drive o_sn_bit=0 from the next edge.

Structure
REQ-025 Package sng_pkg SHALL hold:
- the WIDTH default;
- the SEED default;
- the state enum typedef (IDLE, RUN).
REQ-026 The random source SHALL be sub-module sng_lfsr, with these ports:
- clock;
- synchronous reset;
- load;
- enable;
- seed;
- state output.
REQ-027 The top module SHALL contain the FSM, x_q, the counter, and the output compare register.

Verification
REQ-028 Reset for 2 cycles, then idle -> o_sn_bit=0 on every cycle.
REQ-029 Sweep x=0..15, one start each, collect 16 bits -> popcount equals x in every case; x=0 all 0, x=15 exactly 15 ones.
REQ-030 x=8 with SEED=1 -> the 16-bit stream matches the model sequence; a 32-cycle capture equals the same window twice.
REQ-031 Start x=12, assert stop after 5 bits -> o_sn_bit=0 the following cycle and stays 0; then start and stop together with x=3 -> RUN, 3 ones in the next 16 bits.
REQ-032 Reset asserted mid-RUN (x=10, bit 7) -> o_sn_bit=0 next cycle; then start x=10 -> the stream matches the stream from a fresh start bit for bit.
REQ-033 Toggle i_x_bn randomly during RUN with start low -> the stream is unchanged versus the constant-input run.
